// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Supplies operand values and pending ROB labels at issue, records new ROB
// tags for issued destinations, absorbs the ROB commit stream and clears all
// pending renames on a misprediction flush.
// Optional feature: define RF_PENDING_CNT_EN to add the pending_cnt output.
module reg_file_rename #(
    parameter int REG_COUNT    = 32,
    parameter int REG_WIDTH    = 5,
    parameter int VAL_WIDTH    = 32,
    parameter int ROB_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic [REG_WIDTH-1:0]    rs1,
    input  logic [REG_WIDTH-1:0]    rs2,
    output logic [VAL_WIDTH-1:0]    rf_val1,
    output logic [VAL_WIDTH-1:0]    rf_val2,
    output logic [ROB_ID_WIDTH-1:0] rf_label1,
    output logic [ROB_ID_WIDTH-1:0] rf_label2,
    input  logic                    rename_en,
    input  logic [REG_WIDTH-1:0]    rename_rd,
    input  logic [ROB_ID_WIDTH-1:0] rename_tag,
    input  logic                    commit_en,
    input  logic [REG_WIDTH-1:0]    commit_rd,
    input  logic [VAL_WIDTH-1:0]    commit_res,
    input  logic [ROB_ID_WIDTH-1:0] commit_lab
`ifdef RF_PENDING_CNT_EN
    ,
    output logic [REG_WIDTH:0]      pending_cnt
`endif
);

    logic [VAL_WIDTH-1:0]    val_reg [REG_COUNT];
    logic [ROB_ID_WIDTH-1:0] lab_reg [REG_COUNT];

    // Writes to x0 are dropped, so every fire qualifier excludes index 0
    logic rename_fire;
    logic commit_fire;
    assign rename_fire = rename_en && (rename_rd != '0);
    assign commit_fire = commit_en && (commit_rd != '0);

    // Value and label state: commit writes the value, label priority is
    // flush > rename > matching commit (a newer producer's label survives)
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                val_reg[i] <= '0;
                lab_reg[i] <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (commit_fire && (commit_rd == REG_WIDTH'(i))) begin
                    val_reg[i] <= commit_res;
                end
                if (flush_in) begin
                    lab_reg[i] <= '0;
                end else if (rename_fire && (rename_rd == REG_WIDTH'(i))) begin
                    lab_reg[i] <= rename_tag;
                end else if (commit_fire && (commit_rd == REG_WIDTH'(i)) &&
                             (lab_reg[i] == commit_lab)) begin
                    lab_reg[i] <= '0;
                end
            end
        end
    end

    // Source 1 read: x0 is zero, a matching same-cycle commit is bypassed
    always_comb begin
        rf_val1   = val_reg[rs1];
        rf_label1 = lab_reg[rs1];
        if (rs1 == '0) begin
            rf_val1   = '0;
            rf_label1 = '0;
        end else if (commit_en && (commit_rd == rs1) && (commit_lab == lab_reg[rs1])) begin
            rf_val1   = commit_res;
            rf_label1 = '0;
        end
    end

    // Source 2 read: same rules as source 1
    always_comb begin
        rf_val2   = val_reg[rs2];
        rf_label2 = lab_reg[rs2];
        if (rs2 == '0) begin
            rf_val2   = '0;
            rf_label2 = '0;
        end else if (commit_en && (commit_rd == rs2) && (commit_lab == lab_reg[rs2])) begin
            rf_val2   = commit_res;
            rf_label2 = '0;
        end
    end

`ifdef RF_PENDING_CNT_EN
    localparam logic [REG_WIDTH:0] CNT_ONE = 1;

    logic cnt_inc;
    logic cnt_dec;
    logic [REG_WIDTH:0] pending_cnt_reg;

    // A rename only adds a pending register if its label was zero; a commit
    // only removes one if it clears a live label that a same-cycle rename of
    // the same register does not immediately replace
    assign cnt_inc = rename_fire && (lab_reg[rename_rd] == '0);
    assign cnt_dec = commit_fire && (lab_reg[commit_rd] != '0) &&
                     (lab_reg[commit_rd] == commit_lab) &&
                     !(rename_fire && (rename_rd == commit_rd));

    // Incrementally maintained count of registers with a nonzero label
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pending_cnt_reg <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                pending_cnt_reg <= '0;
            end else if (cnt_inc && !cnt_dec) begin
                pending_cnt_reg <= pending_cnt_reg + CNT_ONE;
            end else if (cnt_dec && !cnt_inc) begin
                pending_cnt_reg <= pending_cnt_reg - CNT_ONE;
            end
        end
    end

    assign pending_cnt = pending_cnt_reg;
`endif

`ifndef SYNTHESIS
    // Label 0 means "no producer", so a rename must carry a real ROB tag
    rename_tag_nonzero: assert property (@(posedge clk) disable iff (!rst_n_in)
        !(rename_en && rdy_in && (rename_tag == '0)));
`endif

endmodule

// File: tb/tb_reg_file_rename.sv
// Self-checking bench for reg_file_rename: directed scenarios plus a random
// run, all compared against a behavioural register/label model.
module tb_reg_file_rename;

    logic        clk;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic [4:0]  rs1, rs2;
    logic [31:0] rf_val1, rf_val2;
    logic [4:0]  rf_label1, rf_label2;
    logic        rename_en;
    logic [4:0]  rename_rd;
    logic [4:0]  rename_tag;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [31:0] commit_res;
    logic [4:0]  commit_lab;
`ifdef RF_PENDING_CNT_EN
    logic [5:0]  pending_cnt;
`endif

    int checks;
    int errors;

    // Reference model state
    logic [31:0] m_val [32];
    logic [4:0]  m_lab [32];

    reg_file_rename dut (
        .clk        (clk),
        .rst_n_in   (rst_n_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .rs1        (rs1),
        .rs2        (rs2),
        .rf_val1    (rf_val1),
        .rf_val2    (rf_val2),
        .rf_label1  (rf_label1),
        .rf_label2  (rf_label2),
        .rename_en  (rename_en),
        .rename_rd  (rename_rd),
        .rename_tag (rename_tag),
        .commit_en  (commit_en),
        .commit_rd  (commit_rd),
        .commit_res (commit_res),
        .commit_lab (commit_lab)
`ifdef RF_PENDING_CNT_EN
        ,
        .pending_cnt(pending_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] m_read_val(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (commit_en && commit_rd == rs && commit_lab == m_lab[rs]) return commit_res;
        return m_val[rs];
    endfunction

    function automatic logic [4:0] m_read_lab(input logic [4:0] rs);
        if (rs == 5'd0) return 5'd0;
        if (commit_en && commit_rd == rs && commit_lab == m_lab[rs]) return 5'd0;
        return m_lab[rs];
    endfunction

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_lab[i] != 5'd0) n++;
        return n;
    endfunction

    task automatic idle();
        rdy_in     = 1'b1;
        flush_in   = 1'b0;
        rename_en  = 1'b0;
        rename_rd  = 5'd0;
        rename_tag = 5'd1;
        commit_en  = 1'b0;
        commit_rd  = 5'd0;
        commit_res = 32'd0;
        commit_lab = 5'd0;
    endtask

    // Advance one clock, updating the model from the architectural rules
    task automatic tick();
        logic [31:0] nv [32];
        logic [4:0]  nl [32];
        nv = m_val;
        nl = m_lab;
        if (rdy_in) begin
            if (commit_en && commit_rd != 5'd0) begin
                nv[commit_rd] = commit_res;
                if (m_lab[commit_rd] == commit_lab) nl[commit_rd] = 5'd0;
            end
            if (rename_en && rename_rd != 5'd0 && !flush_in) nl[rename_rd] = rename_tag;
            if (flush_in) for (int i = 0; i < 32; i++) nl[i] = 5'd0;
        end
        @(posedge clk);
        m_val = nv;
        m_lab = nl;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n_in = 1'b0;
        rs1 = 5'd5;
        rs2 = 5'd0;
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 32'd0;
            m_lab[i] = 5'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rf_val1 !== 32'd0) begin
            errors++; $display("FAIL reset_val1: got %h expected %h", rf_val1, 32'd0);
        end
        checks++;
        if (rf_label1 !== 5'd0) begin
            errors++; $display("FAIL reset_label1: got %0d expected 0", rf_label1);
        end
`ifdef RF_PENDING_CNT_EN
        checks++;
        if (pending_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", pending_cnt);
        end
`endif
        rst_n_in = 1'b1;
        #1;
        $display("reset released, rs1=5 val=%h label=%0d", rf_val1, rf_label1);
    endtask

    task automatic test_commit_basic();
        idle();
        commit_en = 1'b1; commit_rd = 5'd5; commit_res = 32'h1234; commit_lab = 5'd0;
        tick();
        idle();
        rs1 = 5'd5;
        #1;
        checks++;
        if (rf_val1 !== 32'h1234) begin
            errors++; $display("FAIL commit_basic_val: got %h expected %h", rf_val1, 32'h1234);
        end
        checks++;
        if (rf_label1 !== 5'd0) begin
            errors++; $display("FAIL commit_basic_label: got %0d expected 0", rf_label1);
        end
        $display("commit x5=1234: val=%h label=%0d", rf_val1, rf_label1);
    endtask

    task automatic test_rename_commit();
        idle();
        rename_en = 1'b1; rename_rd = 5'd3; rename_tag = 5'd7;
        tick();
        idle();
        rs1 = 5'd3;
        #1;
        checks++;
        if (rf_label1 !== 5'd7) begin
            errors++; $display("FAIL rename_label: got %0d expected 7", rf_label1);
        end
        commit_en = 1'b1; commit_rd = 5'd3; commit_res = 32'hAB; commit_lab = 5'd7;
        #1;
        checks++;
        if (rf_val1 !== 32'hAB || rf_label1 !== 5'd0) begin
            errors++; $display("FAIL commit_bypass: got %h/%0d expected %h/0", rf_val1, rf_label1, 32'hAB);
        end
        tick();
        idle();
        rs1 = 5'd3;
        #1;
        checks++;
        if (rf_val1 !== 32'hAB || rf_label1 !== 5'd0) begin
            errors++; $display("FAIL commit_cleared: got %h/%0d expected %h/0", rf_val1, rf_label1, 32'hAB);
        end
        $display("rename x3 tag7 then commit: val=%h label=%0d", rf_val1, rf_label1);
    endtask

    task automatic test_stale_commit();
        idle();
        rename_en = 1'b1; rename_rd = 5'd4; rename_tag = 5'd2;
        tick();
        rename_tag = 5'd9;
        tick();
        idle();
        commit_en = 1'b1; commit_rd = 5'd4; commit_res = 32'h11; commit_lab = 5'd2;
        tick();
        idle();
        rs1 = 5'd4;
        #1;
        checks++;
        if (rf_val1 !== 32'h11 || rf_label1 !== 5'd9) begin
            errors++; $display("FAIL stale_commit: got %h/%0d expected %h/9", rf_val1, rf_label1, 32'h11);
        end
        $display("stale commit x4: val=%h label=%0d", rf_val1, rf_label1);
    endtask

    task automatic test_same_cycle();
        idle();
        rename_en = 1'b1; rename_rd = 5'd6; rename_tag = 5'd3;
        tick();
        idle();
        rename_en = 1'b1; rename_rd = 5'd6; rename_tag = 5'd4;
        commit_en = 1'b1; commit_rd = 5'd6; commit_res = 32'h66; commit_lab = 5'd3;
        rs2 = 5'd6;
        #1;
        checks++;
        if (rf_val2 !== 32'h66 || rf_label2 !== 5'd0) begin
            errors++; $display("FAIL same_cycle_bypass: got %h/%0d expected %h/0", rf_val2, rf_label2, 32'h66);
        end
        tick();
        idle();
        rs2 = 5'd6;
        #1;
        checks++;
        if (rf_val2 !== 32'h66 || rf_label2 !== 5'd4) begin
            errors++; $display("FAIL same_cycle_state: got %h/%0d expected %h/4", rf_val2, rf_label2, 32'h66);
        end
        $display("rename+commit x6: val=%h label=%0d", rf_val2, rf_label2);
    endtask

    task automatic test_flush();
        idle();
        flush_in = 1'b1;
        tick();
        idle();
        rename_en = 1'b1; rename_rd = 5'd1; rename_tag = 5'd1;
        tick();
        rename_rd = 5'd2; rename_tag = 5'd2;
        tick();
        idle();
        #1;
`ifdef RF_PENDING_CNT_EN
        checks++;
        if (pending_cnt !== 6'd2) begin
            errors++; $display("FAIL flush_cnt_before: got %0d expected 2", pending_cnt);
        end
`endif
        flush_in = 1'b1;
        rename_en = 1'b1; rename_rd = 5'd7; rename_tag = 5'd3;
        commit_en = 1'b1; commit_rd = 5'd1; commit_res = 32'd5; commit_lab = 5'd1;
        tick();
        idle();
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r);
            #1;
            checks++;
            if (rf_label1 !== 5'd0) begin
                errors++; $display("FAIL flush_label_x%0d: got %0d expected 0", r, rf_label1);
            end
        end
        rs1 = 5'd1;
        #1;
        checks++;
        if (rf_val1 !== 32'd5) begin
            errors++; $display("FAIL flush_commit_val: got %h expected %h", rf_val1, 32'd5);
        end
`ifdef RF_PENDING_CNT_EN
        checks++;
        if (pending_cnt !== 6'd0) begin
            errors++; $display("FAIL flush_cnt_after: got %0d expected 0", pending_cnt);
        end
`endif
        $display("flush: x1 val=%h label=%0d", rf_val1, rf_label1);
    endtask

    task automatic test_rdy_low();
        idle();
        rdy_in = 1'b0;
        rename_en = 1'b1; rename_rd = 5'd8; rename_tag = 5'd5;
        commit_en = 1'b1; commit_rd = 5'd1; commit_res = 32'h99; commit_lab = 5'd0;
        tick();
        idle();
        rs1 = 5'd8; rs2 = 5'd1;
        #1;
        checks++;
        if (rf_label1 !== 5'd0 || rf_val1 !== 32'd0) begin
            errors++; $display("FAIL rdy_low_rename: got %h/%0d expected 0/0", rf_val1, rf_label1);
        end
        checks++;
        if (rf_val2 !== 32'd5) begin
            errors++; $display("FAIL rdy_low_commit: got %h expected %h", rf_val2, 32'd5);
        end
        $display("rdy low: x8 label=%0d x1 val=%h", rf_label1, rf_val2);
    endtask

    task automatic test_x0();
        idle();
        commit_en = 1'b1; commit_rd = 5'd0; commit_res = 32'hFFFF; commit_lab = 5'd0;
        rename_en = 1'b1; rename_rd = 5'd0; rename_tag = 5'd5;
        rs1 = 5'd0;
        #1;
        checks++;
        if (rf_val1 !== 32'd0 || rf_label1 !== 5'd0) begin
            errors++; $display("FAIL x0_bypass: got %h/%0d expected 0/0", rf_val1, rf_label1);
        end
        tick();
        idle();
        rs1 = 5'd0;
        #1;
        checks++;
        if (rf_val1 !== 32'd0 || rf_label1 !== 5'd0) begin
            errors++; $display("FAIL x0_write: got %h/%0d expected 0/0", rf_val1, rf_label1);
        end
        $display("x0 write ffff: val=%h label=%0d", rf_val1, rf_label1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            rdy_in    = ($urandom_range(9, 0) != 0);
            flush_in  = ($urandom_range(29, 0) == 0);
            rename_en = $urandom_range(1, 0) == 1;
            rename_rd = 5'($urandom_range(31, 0));
            rename_tag = 5'($urandom_range(31, 1));
            commit_en = $urandom_range(1, 0) == 1;
            commit_rd = 5'($urandom_range(31, 0));
            commit_res = $urandom;
            commit_lab = ($urandom_range(1, 0) == 1) ? m_lab[commit_rd] : 5'($urandom_range(31, 0));
            rs1 = ($urandom_range(3, 0) == 0) ? commit_rd : 5'($urandom_range(31, 0));
            rs2 = ($urandom_range(3, 0) == 0) ? rename_rd : 5'($urandom_range(31, 0));
            #1;
            checks++;
            if (rf_val1 !== m_read_val(rs1) || rf_label1 !== m_read_lab(rs1)) begin
                errors++;
                $display("FAIL rand_port1 n=%0d rs=%0d: got %h/%0d expected %h/%0d",
                         n, rs1, rf_val1, rf_label1, m_read_val(rs1), m_read_lab(rs1));
            end
            checks++;
            if (rf_val2 !== m_read_val(rs2) || rf_label2 !== m_read_lab(rs2)) begin
                errors++;
                $display("FAIL rand_port2 n=%0d rs=%0d: got %h/%0d expected %h/%0d",
                         n, rs2, rf_val2, rf_label2, m_read_val(rs2), m_read_lab(rs2));
            end
`ifdef RF_PENDING_CNT_EN
            checks++;
            if (pending_cnt !== 6'(m_pending())) begin
                errors++;
                $display("FAIL rand_cnt n=%0d: got %0d expected %0d", n, pending_cnt, m_pending());
            end
`endif
            $display("rand %0d: rdy=%0d fl=%0d ren=%0d x%0d t%0d com=%0d x%0d l%0d rs1=%0d v=%h l=%0d pend=%0d",
                     n, rdy_in, flush_in, rename_en, rename_rd, rename_tag, commit_en,
                     commit_rd, commit_lab, rs1, rf_val1, rf_label1, m_pending());
            tick();
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst_n_in = 1'b0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        test_reset();
        test_commit_basic();
        test_rename_commit();
        test_stale_commit();
        test_same_cycle();
        test_flush();
        test_rdy_low();
        test_x0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
